// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//   Front end for the vending FSM. The raw insert/cancel buttons and coin
//   value switches are synchronized. The insert and cancel buttons are then
//   debounced. Each debounced insert press is queued as one coin event in a
//   small FIFO. A cancel press becomes a sticky request.
//
//   Optional build macro: COIN_FIFO_DROP_OLDEST_EN
//     defined   : a push into a full FIFO (no same-cycle pop) discards the
//                 oldest coin and keeps the new one; coin_ovf pulses.
//     undefined : a push into a full FIFO drops the new coin; coin_ovf pulses.
//
//   Ports
//     clk, rst      : clock, synchronous active-high reset
//     insert_raw    : raw coin-insert button (async, bouncy)
//     cancel_raw    : raw cancel button (async, bouncy)
//     coin_val_raw  : raw 2-bit coin value switches (async)
//     coin_valid    : FIFO non-empty, coin_code is valid
//     coin_code     : coin value at FIFO head (registered)
//     coin_ack      : pops the head (one-cycle pulse)
//     coin_count    : number of queued coins
//     cancel_req    : a cancel press is pending
//     cancel_ack    : clears cancel_req
//     coin_ovf      : one-cycle pulse when a push hits a full FIFO
//
//   Handshakes: a coin transfers on any cycle where coin_valid && coin_ack.
//   coin_ack with coin_valid low is ignored. cancel_req stays high until a
//   cycle with cancel_ack. If a new cancel press lands in that same cycle,
//   the request stays set.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          insert_raw,
  input  logic                          cancel_raw,
  input  logic [1:0]                    coin_val_raw,
  output logic                          coin_valid,
  output logic [1:0]                    coin_code,
  input  logic                          coin_ack,
  output logic [$clog2(FIFO_DEPTH):0]   coin_count,
  output logic                          cancel_req,
  input  logic                          cancel_ack,
  output logic                          coin_ovf
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NW-1:0] FULL_N  = NW'(FIFO_DEPTH);

  // Two-flop synchronizers.
  logic       ins_s1, ins_s2, can_s1, can_s2;
  logic [1:0] val_s1, val_s2;

  // Debounce state.
  logic [CW-1:0] ins_cnt, can_cnt;
  logic          ins_lvl, can_lvl, ins_lvl_d, can_lvl_d;

  // Edge events are registered once before they act on the FIFO and on
  // cancel_req. This stage sets the end-to-end latency.
  logic          push_r, can_rise_r;
  logic [1:0]    push_code;

  // FIFO storage and control.
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic          full, pop, do_write, rd_adv, ovf_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_s1 <= 1'b0; ins_s2 <= 1'b0;
      can_s1 <= 1'b0; can_s2 <= 1'b0;
      val_s1 <= '0;   val_s2 <= '0;
    end else begin
      ins_s1 <= insert_raw;   ins_s2 <= ins_s1;
      can_s1 <= cancel_raw;   can_s2 <= can_s1;
      val_s1 <= coin_val_raw; val_s2 <= val_s1;
    end
  end

  // The level flips only after DEBOUNCE_CYCLES consecutive mismatching
  // samples. Any sample that agrees with the level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_cnt <= '0;
      ins_lvl <= 1'b0;
    end else if (ins_s2 == ins_lvl) begin
      ins_cnt <= '0;
    end else if (ins_cnt == CNT_MAX) begin
      ins_lvl <= ~ins_lvl;
      ins_cnt <= '0;
    end else begin
      ins_cnt <= ins_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      can_cnt <= '0;
      can_lvl <= 1'b0;
    end else if (can_s2 == can_lvl) begin
      can_cnt <= '0;
    end else if (can_cnt == CNT_MAX) begin
      can_lvl <= ~can_lvl;
      can_cnt <= '0;
    end else begin
      can_cnt <= can_cnt + CW'(1);
    end
  end

  // Rising edges of the debounced levels. The coin value is captured in the
  // same cycle as the insert edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_lvl_d  <= 1'b0;
      can_lvl_d  <= 1'b0;
      push_r     <= 1'b0;
      can_rise_r <= 1'b0;
      push_code  <= '0;
    end else begin
      ins_lvl_d  <= ins_lvl;
      can_lvl_d  <= can_lvl;
      push_r     <= ins_lvl & ~ins_lvl_d;
      can_rise_r <= can_lvl & ~can_lvl_d;
      push_code  <= val_s2;
    end
  end

  // Set wins over ack, so a press in the ack cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst)             cancel_req <= 1'b0;
    else if (can_rise_r) cancel_req <= 1'b1;
    else if (cancel_ack) cancel_req <= 1'b0;
  end

  assign coin_valid = (coin_count != '0);
  assign full       = (coin_count == FULL_N);
  assign pop        = coin_ack & coin_valid;

  // A pop frees a slot in the same cycle, so push+pop while full both succeed.
  always_comb begin
    do_write = 1'b0;
    rd_adv   = pop;
    ovf_next = 1'b0;
    if (push_r) begin
      if (!full || pop) begin
        do_write = 1'b1;
      end else begin
        ovf_next = 1'b1;
`ifdef COIN_FIFO_DROP_OLDEST_EN
        // Overwrite the oldest slot (wr_ptr == rd_ptr when full) and step
        // the read pointer past it.
        do_write = 1'b1;
        rd_adv   = 1'b1;
`endif
      end
    end
  end

  assign rd_next = rd_ptr + AW'(rd_adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      coin_count <= '0;
      coin_code  <= '0;
      coin_ovf   <= 1'b0;
    end else begin
      if (do_write) mem[wr_ptr] <= push_code;
      wr_ptr   <= wr_ptr + AW'(do_write);
      rd_ptr   <= rd_next;
      coin_ovf <= ovf_next;
      case ({do_write, rd_adv})
        2'b10:   coin_count <= coin_count + NW'(1);
        2'b01:   coin_count <= coin_count - NW'(1);
        default: coin_count <= coin_count;
      endcase
      // The head register must see the coin being written this cycle when
      // that coin lands exactly at the new read position.
      if (do_write || rd_adv) begin
        if (do_write && (rd_next == wr_ptr)) coin_code <= push_code;
        else                                 coin_code <= mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       insert_raw, cancel_raw, coin_ack, cancel_ack;
  logic [1:0] coin_val_raw;
  logic       coin_valid, cancel_req, coin_ovf;
  logic [1:0] coin_code;
  logic [2:0] coin_count;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .insert_raw(insert_raw), .cancel_raw(cancel_raw), .coin_val_raw(coin_val_raw),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_ack(coin_ack),
    .coin_count(coin_count), .cancel_req(cancel_req), .cancel_ack(cancel_ack),
    .coin_ovf(coin_ovf)
  );

  // scoreboard
  logic [1:0] exp_q[$];
  int         exp_ovf    = 0;
  int         ovf_seen   = 0;
  bit         exp_cancel = 0;
  int         checks     = 0;
  int         failures   = 0;

  always @(negedge clk) if (coin_ovf === 1'b1) ovf_seen++;

  typedef struct {
    logic [1:0] code;
    int         exp_count;
    logic [1:0] exp_head;
    int         exp_ovf_total;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [1:0] code);
    if (exp_q.size() == DEPTH) begin
      exp_ovf++;
`ifdef COIN_FIFO_DROP_OLDEST_EN
      void'(exp_q.pop_front());
      exp_q.push_back(code);
`endif
    end else begin
      exp_q.push_back(code);
    end
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, 32'(coin_count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(coin_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(coin_code), 32'(exp_q[0]));
    check({tag, "_ovf_total"}, 32'(ovf_seen), 32'(exp_ovf));
  endtask

  // driver tasks
  task automatic press(input logic [1:0] code, input bit bounce);
    @(negedge clk);
    coin_val_raw = code;
    if (bounce) begin
      for (int k = 0; k < 5; k++) begin
        insert_raw = 1'b1; repeat (2) @(negedge clk);
        insert_raw = 1'b0; @(negedge clk);
      end
    end
    insert_raw = 1'b1; repeat (10) @(negedge clk);
    insert_raw = 1'b0; repeat (10) @(negedge clk);
    model_push(code);
  endtask

  task automatic cancel_press();
    @(negedge clk);
    cancel_raw = 1'b1; repeat (10) @(negedge clk);
    cancel_raw = 1'b0; repeat (10) @(negedge clk);
    exp_cancel = 1'b1;
  endtask

  task automatic ack_one();
    @(negedge clk);
    if (exp_q.size() != 0) check("pop_head", 32'(coin_code), 32'(exp_q.pop_front()));
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
  endtask

  // Raw inputs rise just before edge 0; the event must be visible after
  // edge DEB+3 and not after edge DEB+2.
  task automatic latency_case(input logic [1:0] code, input bit with_cancel);
    @(negedge clk);
    coin_val_raw = code;
    insert_raw   = 1'b1;
    cancel_raw   = with_cancel;
    for (int e = 0; e <= DEB + 3; e++) begin
      @(posedge clk); #1;
      if (e == DEB + 2) check("lat_valid_early", 32'(coin_valid), 32'(0));
    end
    model_push(code);
    if (with_cancel) exp_cancel = 1'b1;
    check("lat_valid", 32'(coin_valid), 32'(1));
    check("lat_code", 32'(coin_code), 32'(code));
    check("lat_count", 32'(coin_count), 32'(1));
    check("lat_cancel", 32'(cancel_req), 32'(exp_cancel));
    @(negedge clk);
    insert_raw = 1'b0;
    cancel_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_fifo("release");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(coin_valid), 32'(0));
    check({tag, "_code"}, 32'(coin_code), 32'(0));
    check({tag, "_count"}, 32'(coin_count), 32'(0));
    check({tag, "_cancel"}, 32'(cancel_req), 32'(0));
    check({tag, "_ovf"}, 32'(coin_ovf), 32'(0));
  endtask

  initial begin
    vecs[0] = '{2'd0, 1, 2'd0, 0};
    vecs[1] = '{2'd1, 2, 2'd0, 0};
    vecs[2] = '{2'd2, 3, 2'd0, 0};
    vecs[3] = '{2'd3, 4, 2'd0, 0};
`ifdef COIN_FIFO_DROP_OLDEST_EN
    vecs[4] = '{2'd1, 4, 2'd1, 1};
`else
    vecs[4] = '{2'd1, 4, 2'd0, 1};
`endif

    rst = 1'b1; insert_raw = 0; cancel_raw = 0; coin_val_raw = 0;
    coin_ack = 0; cancel_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // single held press with exact latency
    latency_case(2'b10, 1'b0);
    ack_one();
    check_fifo("after_pop");

    // ack while empty is ignored
    @(negedge clk); coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    check_fifo("empty_ack");

    // bouncing press gives exactly one coin
    press(2'd3, 1'b1);
    check_fifo("bounce");
    ack_one();

    // table: 5 clean presses, no ack
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].code, 1'b0);
      check($sformatf("vec%0d_count", i), 32'(coin_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_head", i), 32'(coin_code), 32'(vecs[i].exp_head));
      check($sformatf("vec%0d_ovf", i), 32'(ovf_seen), 32'(vecs[i].exp_ovf_total));
      check_fifo($sformatf("vec%0d_sb", i));
    end
    for (int i = 0; i < DEPTH; i++) ack_one();
    check_fifo("drained");

    // full FIFO with ack in the push cycle
    press(2'd1, 0); press(2'd2, 0); press(2'd3, 0); press(2'd0, 0);
    check_fifo("refill");
    @(negedge clk);
    coin_val_raw = 2'd2;
    insert_raw   = 1'b1;
    for (int e = 0; e <= DEB + 3; e++) begin
      @(posedge clk); #1;
      if (e == DEB + 2) begin
        check("coinc_head_before", 32'(coin_code), 32'(exp_q.pop_front()));
        coin_ack = 1'b1;
      end
      if (e == DEB + 3) coin_ack = 1'b0;
    end
    exp_q.push_back(2'd2);
    @(negedge clk); insert_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_fifo("coinc");
    for (int i = 0; i < DEPTH; i++) ack_one();
    check_fifo("coinc_drained");

    // cancel: latency, merge, set-wins
    @(negedge clk);
    cancel_raw = 1'b1;
    for (int e = 0; e <= DEB + 3; e++) begin
      @(posedge clk); #1;
      if (e == DEB + 2) check("cancel_early", 32'(cancel_req), 32'(0));
    end
    exp_cancel = 1'b1;
    check("cancel_lat", 32'(cancel_req), 32'(exp_cancel));
    @(negedge clk); cancel_raw = 1'b0;
    repeat (12) @(negedge clk);
    cancel_press();
    check("cancel_merge", 32'(cancel_req), 32'(exp_cancel));
    @(negedge clk);
    cancel_raw = 1'b1;
    for (int e = 0; e <= DEB + 3; e++) begin
      @(posedge clk); #1;
      if (e == DEB + 2) cancel_ack = 1'b1;
      if (e == DEB + 3) cancel_ack = 1'b0;
    end
    check("cancel_set_wins", 32'(cancel_req), 32'(exp_cancel));
    @(negedge clk); cancel_raw = 1'b0;
    repeat (12) @(negedge clk);
    @(negedge clk); cancel_ack = 1'b1;
    @(negedge clk); cancel_ack = 1'b0;
    exp_cancel = 1'b0;
    check("cancel_cleared", 32'(cancel_req), 32'(exp_cancel));

    // reset mid-operation
    press(2'd1, 0); press(2'd2, 0); press(2'd3, 0);
    cancel_press();
    check_fifo("pre_rst");
    check("pre_rst_cancel", 32'(cancel_req), 32'(exp_cancel));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    exp_cancel = 1'b0;
    check_zero("mid_rst");

    // fresh press after reset, insert and cancel together
    latency_case(2'b01, 1'b1);
    ack_one();
    check_fifo("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
